// File: rtl/double_buffer_pkg.sv
// Shared types and sizing helpers for the ping-pong frame buffer.
package double_buffer_pkg;

    typedef enum logic {
        PAGE0_WRITE = 1'b0,
        PAGE1_WRITE = 1'b1
    } pageSel_e;

    function automatic int addrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int bandwidth(input int blocks, input int blockWidth);
        return blocks * blockWidth;
    endfunction

endpackage

// File: rtl/double_buffer_ram.sv
// Simple dual-port page RAM: synchronous write, registered read with enable.
module double_buffer_ram #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              wInRange;
    logic              rInRange;

    assign wInRange = ({1'b0, waddr_i} < (ADDR_W+1)'(DEPTH));
    assign rInRange = ({1'b0, raddr_i} < (ADDR_W+1)'(DEPTH));

    // Storage has no reset so it maps onto block RAM; a write racing reset is dropped.
    always_ff @(posedge clk_i) begin
        if (we_i && rst_ni && wInRange) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rInRange ? mem[raddr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/double_buffer.sv
// Ping-pong frame buffer: writer fills the back page while the reader scans the front page.
module double_buffer
    import double_buffer_pkg::*;
#(
    parameter int ADDRESS_DEPTH    = 8,
    parameter int BANK_COUNT       = 1,
    parameter int BLOCK_COUNT      = 1,
    parameter int BLOCK_DATA_WIDTH = 8,
    localparam int ADDR_W    = addrWidth(ADDRESS_DEPTH),
    localparam int BANDWIDTH = bandwidth(BLOCK_COUNT, BLOCK_DATA_WIDTH)
) (
    input  logic                          clka,
    input  logic                          rst_n,
    input  logic                          clk_data_in,
    input  logic [ADDR_W-1:0]             ada [BANK_COUNT],
    input  logic [BANDWIDTH-1:0]          din [BANK_COUNT],
    input  logic                          clk_data_out,
    input  logic [ADDR_W-1:0]             adb [BANK_COUNT],
    output logic [BANDWIDTH*BANK_COUNT-1:0] dout_flat,
    input  logic                          swap_trigger,
    output logic                          data_valid
);

    pageSel_e pageSel_q, pageSel_d;
    logic     dataValid_q, dataValid_d;
    logic     readPage_q, readPage_d;
    logic     frontPage;
    logic     writePage;

    logic [BANDWIDTH-1:0] rdData [BANK_COUNT][2];

    assign frontPage = (pageSel_q == PAGE0_WRITE);
    assign writePage = ~frontPage;

    // readPage remembers which page produced the held read data, so a swap
    // without a new read leaves dout_flat untouched.
    always_comb begin
        pageSel_d   = pageSel_q;
        dataValid_d = dataValid_q | swap_trigger;
        readPage_d  = readPage_q;
        if (swap_trigger) begin
            pageSel_d = (pageSel_q == PAGE0_WRITE) ? PAGE1_WRITE : PAGE0_WRITE;
        end
        if (clk_data_out) begin
            readPage_d = frontPage;
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            pageSel_q   <= PAGE0_WRITE;
            dataValid_q <= 1'b0;
            readPage_q  <= 1'b1;
        end else begin
            pageSel_q   <= pageSel_d;
            dataValid_q <= dataValid_d;
            readPage_q  <= readPage_d;
        end
    end

    for (genvar b = 0; b < BANK_COUNT; b++) begin : gBank
        for (genvar p = 0; p < 2; p++) begin : gPage
            double_buffer_ram #(
                .DEPTH  (ADDRESS_DEPTH),
                .ADDR_W (ADDR_W),
                .DATA_W (BANDWIDTH)
            ) uRam (
                .clk_i   (clka),
                .rst_ni  (rst_n),
                .we_i    (clk_data_in && (writePage == 1'(p))),
                .waddr_i (ada[b]),
                .wdata_i (din[b]),
                .re_i    (clk_data_out && (frontPage == 1'(p))),
                .raddr_i (adb[b]),
                .rdata_o (rdData[b][p])
            );
        end
    end

    always_comb begin
        dout_flat = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            dout_flat[b*BANDWIDTH +: BANDWIDTH] = readPage_q ? rdData[b][1] : rdData[b][0];
        end
    end

    assign data_valid = dataValid_q;

endmodule

// File: tb/tb_double_buffer.sv
// Directed self-checking bench for double_buffer, built with two banks.
module tb_double_buffer;

    logic        clka;
    logic        rst_n;
    logic        clk_data_in;
    logic [2:0]  ada [2];
    logic [7:0]  din [2];
    logic        clk_data_out;
    logic [2:0]  adb [2];
    logic [15:0] dout_flat;
    logic        swap_trigger;
    logic        data_valid;

    int checks   = 0;
    int failures = 0;

    double_buffer #(
        .ADDRESS_DEPTH    (8),
        .BANK_COUNT       (2),
        .BLOCK_COUNT      (1),
        .BLOCK_DATA_WIDTH (8)
    ) dut (
        .clka         (clka),
        .rst_n        (rst_n),
        .clk_data_in  (clk_data_in),
        .ada          (ada),
        .din          (din),
        .clk_data_out (clk_data_out),
        .adb          (adb),
        .dout_flat    (dout_flat),
        .swap_trigger (swap_trigger),
        .data_valid   (data_valid)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] wa0, input logic [7:0] wd0,
                                 input logic [2:0] wa1, input logic [7:0] wd1,
                                 input logic re, input logic [2:0] ra0, input logic [2:0] ra1,
                                 input logic swap);
        clk_data_in  = we;
        ada[0]       = wa0;
        din[0]       = wd0;
        ada[1]       = wa1;
        din[1]       = wd1;
        clk_data_out = re;
        adb[0]       = ra0;
        adb[1]       = ra1;
        swap_trigger = swap;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        tick();
        checkOutput("reset_dout", dout_flat, 16'h0000);
        checkOutput("reset_valid", {15'd0, data_valid}, 16'h0000);
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("post_reset_dout", dout_flat, 16'h0000);
        checkOutput("post_reset_valid", {15'd0, data_valid}, 16'h0000);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 3'(i), 8'hA0 + 8'(i), 3'(i), 8'h50 + 8'(i), 0, 0, 0, 0);
        end
        checkOutput("valid_before_swap", {15'd0, data_valid}, 16'h0000);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("valid_after_swap", {15'd0, data_valid}, 16'h0001);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 3'(i), 3'(i), 0);
            checkOutput($sformatf("readA_%0d", i), dout_flat, {8'h50 + 8'(i), 8'hA0 + 8'(i)});
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 3'(i), 8'hB0 + 8'(i), 3'(i), 8'h60 + 8'(i), 0, 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 3'(i), 3'(i), 0);
            checkOutput($sformatf("noswap_readA_%0d", i), dout_flat[7:0], 16'hA0 + 16'(i));
        end
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("valid_sticky", {15'd0, data_valid}, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 3'(i), 3'(i), 0);
            checkOutput($sformatf("readB_%0d", i), dout_flat[7:0], 16'hB0 + 16'(i));
        end

        applyStimulus(1, 3'd2, 8'hC5, 3'd2, 8'h77, 1, 3'd1, 3'd1, 1);
        checkOutput("read_on_swap_old_page", dout_flat[7:0], 16'h00B1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 3'd2, 3'd2, 0);
        checkOutput("write_on_swap_lands", dout_flat[7:0], 16'h00C5);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 3'(i + 3), 3'(i), 0);
            checkOutput($sformatf("hold_%0d", i), dout_flat[7:0], 16'h00C5);
        end

        applyStimulus(1, 3'd1, 8'h11, 3'd1, 8'h22, 0, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 3'd1, 3'd1, 0);
        checkOutput("two_bank_read", dout_flat, 16'h2211);

        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", {15'd0, data_valid}, 16'h0000);
        checkOutput("async_reset_dout", dout_flat, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("after_reset_pulse_valid", {15'd0, data_valid}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
